wb_write_scheduler: RTL and testbench
=====================================

Name: wb_write_scheduler

Overview:
- Sits between the pipeline write-back stage outputs and a single-write-port 16x64 register file.
- Each retiring instruction can produce two writes per cycle (dstE, dstM). The block queues them in a small in-order FIFO and drains one per cycle.
- Back-pressures the pipeline via wb_stall.
- Sequences processor halt on a non-AOK status: drains the queue, then parks in HALTED.

Parameters:
- DEPTH, 4, number of queued register writes; power of 2, minimum 2.
- RNONE, 4'hF, register ID meaning "no destination".
- SAOK, 4'h1, status code for normal operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- w_valid  in  1  write-back stage holds a real instruction (0 = bubble).
- w_stat  in  4  status of the write-back instruction.
- w_dstE  in  4  destination ID for valE; RNONE means no write.
- w_dstM  in  4  destination ID for valM; RNONE means no write.
- w_valE  in  64  ALU result.
- w_valM  in  64  memory result.
- wb_stall  out  1  pipeline must hold the write-back instruction this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  register file write address.
- rf_wdata  out  64  register file write data.
- fwd_addr  in  4  forwarding lookup register ID.
- fwd_hit  out  1  fwd_addr has a pending queued write.
- fwd_data  out  64  value of the youngest pending write to fwd_addr.
- halted  out  1  processor halted; all writes retired.
- cpu_stat  out  4  latched final status.

Behaviour:
- State machine RUN -> DRAIN -> HALTED. Reset state is RUN.
- Reset values:
  - count=0, queue pointers=0.
  - rf_we=0, rf_waddr=RNONE, rf_wdata=0.
  - wb_stall=0, halted=0, cpu_stat=SAOK, fwd_hit=0, fwd_data=0.
- Reset asserted mid-operation discards all queued writes; none reach the register file.
- Accept condition (RUN only): w_valid && !wb_stall && w_stat==SAOK.
  - On accept, enqueue dstE entry if w_dstE!=RNONE, then dstM entry if w_dstM!=RNONE.
  - Enqueue order is E then M, so an M write to the same register is applied later and wins.
  - n_in is 0, 1 or 2.
- Port drive is combinational from the FIFO head:
  - rf_we = (count!=0); rf_waddr/rf_wdata = head entry.
  - When count==0: rf_waddr=RNONE, rf_wdata=0.
  - The head is popped at the same edge the register file writes it.
- Latency: a write enqueued at edge N into an empty queue is written to the register file at edge N+1.
- Simultaneous push and pop: count_next = count + n_in - (count!=0). Pointers wrap modulo DEPTH.
- wb_stall:
  - RUN: wb_stall = (count > DEPTH-2), i.e. fewer than 2 free slots. Ignores the same-cycle pop, so overflow is impossible.
  - DRAIN and HALTED: wb_stall = 1.
- Halt sequencing:
  - In RUN, w_valid && !wb_stall && w_stat!=SAOK: nothing enqueued, cpu_stat<=w_stat, next state DRAIN.
  - A stalled or bubble cycle never triggers halt.
  - DRAIN: no enqueue; queue keeps popping. When count==0 (or count==1 with a pop this edge), move to HALTED.
  - HALTED: halted=1, rf_we=0. Sticky until reset.
- Forwarding lookup:
  - fwd_hit=1 iff fwd_addr!=RNONE and some occupied entry matches; fwd_data is the youngest matching entry.
  - The head entry being written this cycle still counts as a hit.
  - Combinational; no hit when count==0.

Optional Feature:
- Macro WB_SCHED_FWD_EN.
- Defined: forwarding comparators and youngest-match priority logic built as described.
- Undefined: fwd_hit tied 0 and fwd_data tied 0; fwd_addr ignored. The pipeline must then stall on any hazard against a non-empty queue.

Test Plan:
- Reset then single write: w_valid=1, w_stat=1, dstE=3, valE=0x11, dstM=F -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11; following cycle rf_we=0.
- Dual write same register: dstE=4 (valE=0xAA), dstM=4 (valM=0xBB) -> two consecutive writes to reg 4, 0xAA then 0xBB; fwd_addr=4 gives fwd_hit=1, fwd_data=0xBB while both are queued.
- Back-pressure, DEPTH=4: three back-to-back dual-write instructions -> wb_stall=1 once count=3; third instruction accepted only after wb_stall drops; six writes emerge in order with no loss or duplication.
- Halt: enqueue two writes, then w_stat=2 (HLT) valid -> wb_stall=1 immediately; both writes retire; halted=1 and cpu_stat=2 the cycle after the last write; later SAOK inputs are ignored.
- Reset mid-drain: rst_n=0 for one cycle with count=3 -> rf_we=0, count=0, halted=0, cpu_stat=1; no stale writes after reset.
- Bubble and RNONE: w_valid=0 with dstE=2, or w_valid=1 with both dst=F -> no enqueue, rf_we stays 0, fwd_hit=0 for fwd_addr=F.

Source files
------------

// File: rtl/wb_write_scheduler_if.sv
// Write-back stage to register-file scheduler bus: pipeline write-back inputs,
// register-file write port, forwarding lookup and halt status.
interface wb_write_scheduler_if;
    logic        w_valid;
    logic [3:0]  w_stat;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic        wb_stall;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        halted;
    logic [3:0]  cpu_stat;

    modport master (
        output w_valid, w_stat, w_dstE, w_dstM, w_valE, w_valM, fwd_addr,
        input  wb_stall, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, halted, cpu_stat
    );

    modport slave (
        input  w_valid, w_stat, w_dstE, w_dstM, w_valE, w_valM, fwd_addr,
        output wb_stall, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, halted, cpu_stat
    );
endinterface

// File: rtl/wb_write_scheduler.sv
// Queues up to two register writes per retiring instruction and drains one per cycle,
// then sequences halt. Define WB_SCHED_FWD_EN to build the forwarding lookup.
module wb_write_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter logic [3:0]  RNONE = 4'hF,
    parameter logic [3:0]  SAOK  = 4'h1
) (
    input logic                 clk,
    input logic                 rst_n,
    wb_write_scheduler_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    cpu_stat_q, cpu_stat_d;
    logic [3:0]    addr_q [DEPTH];
    logic [3:0]    addr_d [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [63:0]   data_d [DEPTH];

    logic pop, stall, take, push_e, push_m;

    always_comb begin
        pop    = (count_q != '0);
        // Stall ignores the same-cycle pop so a dual push can never overflow.
        stall  = (state_q != StRun) || (count_q > CW'(DEPTH - 2));
        take   = (state_q == StRun) && bus.w_valid && !stall;
        push_e = take && (bus.w_stat == SAOK) && (bus.w_dstE != RNONE);
        push_m = take && (bus.w_stat == SAOK) && (bus.w_dstM != RNONE);

        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        if (push_e) begin
            addr_d[wr_ptr_d] = bus.w_dstE;
            data_d[wr_ptr_d] = bus.w_valE;
            wr_ptr_d         = wr_ptr_d + AW'(1);
        end
        if (push_m) begin
            addr_d[wr_ptr_d] = bus.w_dstM;
            data_d[wr_ptr_d] = bus.w_valM;
            wr_ptr_d         = wr_ptr_d + AW'(1);
        end
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_e) + CW'(push_m) - CW'(pop);

        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        case (state_q)
            StRun: begin
                if (take && (bus.w_stat != SAOK)) begin
                    state_d    = StDrain;
                    cpu_stat_d = bus.w_stat;
                end
            end
            StDrain: begin
                if (count_q <= CW'(1)) state_d = StHalted;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cpu_stat_q <= SAOK;
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cpu_stat_q <= cpu_stat_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.wb_stall = stall;
    assign bus.rf_we    = pop;
    assign bus.rf_waddr = pop ? addr_q[rd_ptr_q] : RNONE;
    assign bus.rf_wdata = pop ? data_q[rd_ptr_q] : 64'h0;
    assign bus.halted   = (state_q == StHalted);
    assign bus.cpu_stat = cpu_stat_q;

`ifdef WB_SCHED_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = 64'h0;
        fwd_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            if ((CW'(i) < count_q) && (bus.fwd_addr != RNONE) &&
                (addr_q[fwd_idx] == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^bus.fwd_addr;
    assign bus.fwd_hit     = 1'b0;
    assign bus.fwd_data    = 64'h0;
`endif

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: fixed vector table, halt/reset sequences and
// random traffic checked against a queue-based reference model.
module tb_wb_write_scheduler;
    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  RNONE = 4'hF;
    localparam logic [3:0]  SAOK  = 4'h1;
`ifdef WB_SCHED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_scheduler_if bus ();

    wb_write_scheduler #(
        .DEPTH(DEPTH),
        .RNONE(RNONE),
        .SAOK (SAOK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] st, input logic [3:0] e,
                         input logic [3:0] m, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] fa);
        bus.w_valid  = v;
        bus.w_stat   = st;
        bus.w_dstE   = e;
        bus.w_dstM   = m;
        bus.w_valE   = ve;
        bus.w_valM   = vm;
        bus.fwd_addr = fa;
    endtask

    // Reference model: the queue is the list of pending writes, oldest first.
    typedef struct packed {
        logic [3:0]  a;
        logic [63:0] d;
    } ent_t;
    ent_t       mq[$];
    int         mode = 0;  // 0 running, 1 draining, 2 halted
    logic [3:0] m_stat = SAOK;

    function automatic bit m_stall();
        return (mode != 0) || (mq.size() > int'(DEPTH) - 2);
    endfunction

    task automatic check_model(input string tag);
        logic        hit;
        logic [63:0] fd;
        hit = 1'b0;
        fd  = 64'h0;
        if (FWD && bus.fwd_addr != RNONE) begin
            foreach (mq[i]) if (mq[i].a == bus.fwd_addr) begin
                hit = 1'b1;
                fd  = mq[i].d;
            end
        end
        cmp({tag, ".rf_we"}, 64'(bus.rf_we), 64'(mq.size() != 0));
        cmp({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'((mq.size() != 0) ? mq[0].a : RNONE));
        cmp({tag, ".rf_wdata"}, bus.rf_wdata, (mq.size() != 0) ? mq[0].d : 64'h0);
        cmp({tag, ".wb_stall"}, 64'(bus.wb_stall), 64'(m_stall()));
        cmp({tag, ".fwd_hit"}, 64'(bus.fwd_hit), 64'(hit));
        cmp({tag, ".fwd_data"}, bus.fwd_data, fd);
        cmp({tag, ".halted"}, 64'(bus.halted), 64'(mode == 2));
        cmp({tag, ".cpu_stat"}, 64'(bus.cpu_stat), 64'(m_stat));
    endtask

    task automatic model_edge();
        int old_mode;
        bit st;
        if (!rst_n) begin
            mq.delete();
            mode   = 0;
            m_stat = SAOK;
            return;
        end
        old_mode = mode;
        st       = m_stall();
        if (mq.size() != 0) void'(mq.pop_front());
        if (old_mode == 0 && bus.w_valid && !st) begin
            if (bus.w_stat == SAOK) begin
                if (bus.w_dstE != RNONE) mq.push_back('{a: bus.w_dstE, d: bus.w_valE});
                if (bus.w_dstM != RNONE) mq.push_back('{a: bus.w_dstM, d: bus.w_valM});
            end else begin
                m_stat = bus.w_stat;
                mode   = 1;
            end
        end else if (old_mode == 1 && mq.size() == 0) begin
            mode = 2;
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, SAOK, RNONE, RNONE, 64'h0, 64'h0, RNONE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        mode   = 0;
        m_stat = SAOK;
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  st, e, m;
        logic [63:0] ve, vm;
        logic [3:0]  fa;
        logic        we;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic        stall, hit;
        logic [63:0] fd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] st, input logic [3:0] e,
                                input logic [3:0] m, input logic [63:0] ve,
                                input logic [63:0] vm, input logic [3:0] fa, input logic we,
                                input logic [3:0] wa, input logic [63:0] wd,
                                input logic stall, input logic hit, input logic [63:0] fd);
        vec_t r;
        r = '{v, st, e, m, ve, vm, fa, we, wa, wd, stall, hit, fd};
        return r;
    endfunction

    vec_t tbl[14];

    initial begin
        // Each row: inputs held for one cycle, outputs expected during that cycle.
        tbl[0]  = mk(1'b1, 4'h1, 4'h3, 4'hF, 64'h11, 64'h0,  4'h3, 1'b0, 4'hF, 64'h0,  1'b0, 1'b0, 64'h0);
        tbl[1]  = mk(1'b0, 4'h1, 4'h2, 4'hF, 64'h22, 64'h0,  4'h3, 1'b1, 4'h3, 64'h11, 1'b0, 1'b1, 64'h11);
        tbl[2]  = mk(1'b1, 4'h1, 4'h4, 4'h4, 64'hAA, 64'hBB, 4'h4, 1'b0, 4'hF, 64'h0,  1'b0, 1'b0, 64'h0);
        tbl[3]  = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h4, 1'b1, 4'h4, 64'hAA, 1'b0, 1'b1, 64'hBB);
        tbl[4]  = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h4, 1'b1, 4'h4, 64'hBB, 1'b0, 1'b1, 64'hBB);
        tbl[5]  = mk(1'b1, 4'h1, 4'hF, 4'hF, 64'h55, 64'h66, 4'hF, 1'b0, 4'hF, 64'h0,  1'b0, 1'b0, 64'h0);
        tbl[6]  = mk(1'b1, 4'h1, 4'h1, 4'h2, 64'hA1, 64'hA2, 4'h2, 1'b0, 4'hF, 64'h0,  1'b0, 1'b0, 64'h0);
        tbl[7]  = mk(1'b1, 4'h1, 4'h5, 4'h6, 64'hB5, 64'hB6, 4'h1, 1'b1, 4'h1, 64'hA1, 1'b0, 1'b1, 64'hA1);
        tbl[8]  = mk(1'b1, 4'h1, 4'h7, 4'h8, 64'hC7, 64'hC8, 4'h6, 1'b1, 4'h2, 64'hA2, 1'b1, 1'b1, 64'hB6);
        tbl[9]  = mk(1'b1, 4'h1, 4'h7, 4'h8, 64'hC7, 64'hC8, 4'h7, 1'b1, 4'h5, 64'hB5, 1'b0, 1'b0, 64'h0);
        tbl[10] = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h8, 1'b1, 4'h6, 64'hB6, 1'b1, 1'b1, 64'hC8);
        tbl[11] = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h5, 1'b1, 4'h7, 64'hC7, 1'b0, 1'b0, 64'h0);
        tbl[12] = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h8, 1'b1, 4'h8, 64'hC8, 1'b0, 1'b1, 64'hC8);
        tbl[13] = mk(1'b0, 4'h1, 4'hF, 4'hF, 64'h0,  64'h0,  4'h0, 1'b0, 4'hF, 64'h0,  1'b0, 1'b0, 64'h0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].e, tbl[i].m, tbl[i].ve, tbl[i].vm, tbl[i].fa);
            @(negedge clk);
            cmp($sformatf("tbl%0d.rf_we", i), 64'(bus.rf_we), 64'(tbl[i].we));
            cmp($sformatf("tbl%0d.rf_waddr", i), 64'(bus.rf_waddr), 64'(tbl[i].wa));
            cmp($sformatf("tbl%0d.rf_wdata", i), bus.rf_wdata, tbl[i].wd);
            cmp($sformatf("tbl%0d.wb_stall", i), 64'(bus.wb_stall), 64'(tbl[i].stall));
            cmp($sformatf("tbl%0d.fwd_hit", i), 64'(bus.fwd_hit), 64'(tbl[i].hit & FWD));
            cmp($sformatf("tbl%0d.fwd_data", i), bus.fwd_data, FWD ? tbl[i].fd : 64'h0);
            cmp($sformatf("tbl%0d.halted", i), 64'(bus.halted), 64'h0);
            cmp($sformatf("tbl%0d.cpu_stat", i), 64'(bus.cpu_stat), 64'(SAOK));
            @(posedge clk);
            #1;
        end

        // Halt: two queued writes retire, then halted is sticky and later input ignored.
        do_reset();
        drive(1'b1, SAOK, 4'h9, 4'hA, 64'h91, 64'hA0, 4'hA);
        tick("halt_pre");
        drive(1'b1, 4'h2, 4'h1, 4'h2, 64'h1, 64'h2, 4'h9);
        tick("halt_req");
        drive(1'b1, SAOK, 4'h3, 4'h4, 64'h33, 64'h44, 4'h3);
        for (int i = 0; i < 5; i++) tick("halt_after");
        @(negedge clk);
        cmp("halt.halted", 64'(bus.halted), 64'h1);
        cmp("halt.cpu_stat", 64'(bus.cpu_stat), 64'h2);
        cmp("halt.rf_we", 64'(bus.rf_we), 64'h0);
        cmp("halt.wb_stall", 64'(bus.wb_stall), 64'h1);
        @(posedge clk);
        #1;

        // Reset with three writes pending: nothing stale may emerge afterwards.
        do_reset();
        drive(1'b1, SAOK, 4'h1, 4'h2, 64'h101, 64'h102, 4'h2);
        tick("rst_fill0");
        drive(1'b1, SAOK, 4'h3, 4'h4, 64'h103, 64'h104, 4'h2);
        tick("rst_fill1");
        drive(1'b0, SAOK, RNONE, RNONE, 64'h0, 64'h0, 4'h3);
        rst_n = 1'b0;
        tick("rst_hit");
        rst_n = 1'b1;
        @(negedge clk);
        cmp("rst.rf_we", 64'(bus.rf_we), 64'h0);
        cmp("rst.rf_waddr", 64'(bus.rf_waddr), 64'(RNONE));
        cmp("rst.fwd_hit", 64'(bus.fwd_hit), 64'h0);
        cmp("rst.halted", 64'(bus.halted), 64'h0);
        cmp("rst.cpu_stat", 64'(bus.cpu_stat), 64'(SAOK));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick("rst_after");

        // Random traffic against the model, with occasional halts and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = !(($urandom_range(0, 99) == 0) || (mode == 2 && $urandom_range(0, 5) == 0));
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : SAOK,
                  ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 5)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 6) == 6) ? RNONE : 4'($urandom_range(0, 5)));
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
